inst_fetch_queue: RTL and testbench



---
 rtl/inst_fetch_queue.sv | 132 +++++++++++++
 tb/tb_inst_fetch_queue.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction fetch front end.
// Owns the PC and drives it to a zero-latency instruction ROM. Each returned
// word is captured with its PC into a small circular queue that feeds decode.
// Redirects from later stages flush the queue and reload the PC.
// Optional build macro FETCH_HALT_EN adds a 'halted' output. When it is
// defined, fetch stops after an all-zero instruction has been enqueued.
module inst_fetch_queue #(
    parameter int ADDR_W   = 12,
    parameter int INST_W   = 19,
    parameter int QDEPTH   = 4,
    parameter int RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [ADDR_W-1:0]          pc,
    input  logic [INST_W-1:0]          instruction,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    input  logic                       id_ready,
    output logic                       id_valid,
    output logic [INST_W-1:0]          id_inst,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [ADDR_W-1:0]          id_pc_plus1,
    output logic [$clog2(QDEPTH):0]    q_count
`ifdef FETCH_HALT_EN
    ,
    output logic                       halted
`endif
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [PW-1:0]     PTR_ONE  = PW'(1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]     CNT_FULL = CW'(QDEPTH);
    localparam logic [ADDR_W-1:0] PC_RST   = ADDR_W'(RESET_PC);

    // Architectural state
    logic [ADDR_W-1:0] r_pc;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;

    // Queue storage; no reset needed because r_count gates visibility
    logic [INST_W-1:0] r_inst_mem [QDEPTH];
    logic [ADDR_W-1:0] r_pc_mem   [QDEPTH];

    logic              w_pop;
    logic              w_push;
    logic              w_not_full;
    logic              w_fetch_block;
    logic [INST_W-1:0] w_head_inst;
    logic [ADDR_W-1:0] w_head_pc;

`ifdef FETCH_HALT_EN
    logic r_halted;
    assign halted        = r_halted;
    assign w_fetch_block = r_halted;
`else
    assign w_fetch_block = 1'b0;
`endif

    assign id_valid   = (r_count != '0);
    assign w_pop      = id_valid & id_ready;
    assign w_not_full = (r_count < CNT_FULL);
    // A push is allowed into a full queue when the head leaves on the same edge
    assign w_push     = !redirect_valid & (w_not_full | w_pop) & !w_fetch_block;

    assign w_head_inst = r_inst_mem[r_rd_ptr];
    assign w_head_pc   = r_pc_mem[r_rd_ptr];

    // Head outputs are forced to zero when the queue is empty
    assign id_inst     = id_valid ? w_head_inst : '0;
    assign id_pc       = id_valid ? w_head_pc : '0;
    assign id_pc_plus1 = id_valid ? (w_head_pc + ADDR_ONE) : '0;

    assign pc      = r_pc;
    assign q_count = r_count;

    // Queue write port: capture the current PC and ROM word on each push
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_inst_mem[r_wr_ptr] <= instruction;
            r_pc_mem[r_wr_ptr]   <= r_pc;
        end
    end

    // PC, pointers and occupancy: reset beats redirect, redirect beats push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= PC_RST;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            // Flush: any pop this cycle is dropped, nothing is enqueued
            r_pc     <= redirect_pc;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + ADDR_ONE;
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FETCH_HALT_EN
    // Halt latch: set when a zero word is enqueued, cleared by redirect or reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (redirect_valid) begin
            r_halted <= 1'b0;
        end else if (w_push && (instruction == '0)) begin
            r_halted <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed testbench for inst_fetch_queue. The ROM model returns k+1 for
// word k (and 0 for word 9 when FETCH_HALT_EN is defined).
module tb_inst_fetch_queue;

    localparam int ADDR_W = 12;
    localparam int INST_W = 19;
    localparam int QDEPTH = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [ADDR_W-1:0]   pc;
    logic [INST_W-1:0]   instruction;
    logic                redirect_valid = 1'b0;
    logic [ADDR_W-1:0]   redirect_pc = '0;
    logic                id_ready = 1'b0;
    logic                id_valid;
    logic [INST_W-1:0]   id_inst;
    logic [ADDR_W-1:0]   id_pc;
    logic [ADDR_W-1:0]   id_pc_plus1;
    logic [2:0]          q_count;
`ifdef FETCH_HALT_EN
    logic                halted;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Combinational ROM model
    always_comb begin
        instruction = INST_W'(pc) + INST_W'(1);
`ifdef FETCH_HALT_EN
        if (pc == ADDR_W'(9)) instruction = '0;
`endif
    end

    inst_fetch_queue #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .QDEPTH(QDEPTH), .RESET_PC(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pc(pc),
        .instruction(instruction),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .id_ready(id_ready),
        .id_valid(id_valid),
        .id_inst(id_inst),
        .id_pc(id_pc),
        .id_pc_plus1(id_pc_plus1),
        .q_count(q_count)
`ifdef FETCH_HALT_EN
        ,
        .halted(halted)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input int epc, input int einst);
        check({tag, ".valid"}, 32'(id_valid), 32'd1);
        check({tag, ".pc"},    32'(id_pc),    32'(epc));
        check({tag, ".inst"},  32'(id_inst),  32'(einst));
    endtask

    initial begin
        // ---- reset state ----
        step(); step();
        check("rst.pc",      32'(pc),          32'd0);
        check("rst.count",   32'(q_count),     32'd0);
        check("rst.valid",   32'(id_valid),    32'd0);
        check("rst.inst",    32'(id_inst),     32'd0);
        check("rst.idpc",    32'(id_pc),       32'd0);
        check("rst.idpc1",   32'(id_pc_plus1), 32'd0);

        // ---- streaming with id_ready=1 ----
        rst = 1'b0; id_ready = 1'b1;
        check("s.pc0", 32'(pc), 32'd0);
        check("s.valid0", 32'(id_valid), 32'd0);
        step();
        check("s.pc1", 32'(pc), 32'd1);
        head("s.h0", 0, 1);
        check("s.h0.pc1", 32'(id_pc_plus1), 32'd1);
        step();
        head("s.h1", 1, 2);
        check("s.cnt", 32'(q_count), 32'd1);
        step();
        head("s.h2", 2, 3);
        check("s.pc3", 32'(pc), 32'd3);

        // ---- fill with id_ready=0 ----
        rst = 1'b1; step(); rst = 1'b0; id_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("f.count", 32'(q_count), 32'd4);
        check("f.pc",    32'(pc),      32'd4);
        head("f.h", 0, 1);

        // Full with pop: push of pc 4 happens on the same edge
        id_ready = 1'b1;
        step();
        check("fp.count", 32'(q_count), 32'd4);
        check("fp.pc",    32'(pc),      32'd5);
        head("fp.h", 1, 2);
        for (int k = 2; k <= 4; k++) begin
            step();
            head($sformatf("drain%0d", k), k, k + 1);
        end

        // ---- redirect with 3 entries queued ----
        rst = 1'b1; step(); rst = 1'b0; id_ready = 1'b0;
        step(); step(); step();
        check("r.count3", 32'(q_count), 32'd3);
        redirect_valid = 1'b1; redirect_pc = 12'h123;
        step();
        check("r.count0", 32'(q_count), 32'd0);
        check("r.pc",     32'(pc),      32'h123);
        check("r.valid0", 32'(id_valid), 32'd0);
        check("r.inst0",  32'(id_inst),  32'd0);
        redirect_valid = 1'b0; id_ready = 1'b1;
        step();
        head("r.h", 'h123, 'h124);
        check("r.pcnext", 32'(pc), 32'h124);

        // ---- wrap around the address space ----
        redirect_valid = 1'b1; redirect_pc = 12'hFFF;
        step();
        check("w.pc", 32'(pc), 32'hFFF);
        redirect_valid = 1'b0;
        step();
        head("w.h0", 'hFFF, 'h1000);
        check("w.pc1", 32'(id_pc_plus1), 32'h000);
        check("w.pcwrap", 32'(pc), 32'h000);
        step();
        head("w.h1", 0, 1);
        check("w.pc1b", 32'(id_pc_plus1), 32'h001);
        step();
        head("w.h2", 1, 2);

        // ---- redirect held two cycles: reload each cycle, nothing queued ----
        redirect_valid = 1'b1; redirect_pc = 12'h040;
        step();
        redirect_pc = 12'h080;
        step();
        check("hold.pc",    32'(pc),      32'h080);
        check("hold.count", 32'(q_count), 32'd0);
        redirect_valid = 1'b0;
        step();
        head("hold.h", 'h080, 'h081);

        // ---- reset beats a simultaneous redirect ----
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 12'h555;
        step();
        check("rr.pc",    32'(pc),      32'd0);
        check("rr.count", 32'(q_count), 32'd0);
        rst = 1'b0; redirect_valid = 1'b0;

`ifdef FETCH_HALT_EN
        // ---- halt on zero word at address 9 ----
        id_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("h.halted", 32'(halted), 32'd1);
        check("h.pc",     32'(pc),     32'd10);
        head("h.h9", 9, 0);
        step();
        check("h.empty", 32'(id_valid), 32'd0);
        check("h.pchold", 32'(pc), 32'd10);
        redirect_valid = 1'b1; redirect_pc = 12'h002;
        step();
        check("h.clear", 32'(halted), 32'd0);
        check("h.pc2",   32'(pc),     32'd2);
        redirect_valid = 1'b0;
        step();
        head("h.resume", 2, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
